// File: rtl/sauria_pe_pkg.sv
// Shared types and helpers for the systolic-array PE accumulator slice.
package sauria_pe_pkg;

  // Widest accumulator any PE variant may use; helpers work at this width
  // and callers truncate to their own ACC_W.
  localparam int unsigned ACC_W_MAX = 64;

  typedef logic signed [ACC_W_MAX-1:0] acc_t;

  // Full-width saturation bounds; narrowed per instance by sat_hi/sat_lo.
  localparam acc_t ACC_MAX = {1'b0, {(ACC_W_MAX-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W_MAX-1){1'b0}}};

  // Stage-2 action for the accumulator register.
  typedef enum logic [1:0] {
    ACC_HOLD,
    ACC_LOAD,
    ACC_ZERO,
    ACC_ADD
  } acc_op_e;

  // Sign-extend a zero-padded mul_w-bit product to the full helper width.
  function automatic acc_t sext_prod(input acc_t raw, input int unsigned mul_w);
    return (raw <<< (ACC_W_MAX - mul_w)) >>> (ACC_W_MAX - mul_w);
  endfunction

  // Largest positive value representable in w bits (sign-extended).
  function automatic acc_t sat_hi(input int unsigned w);
    return ACC_MAX >>> (ACC_W_MAX - w);
  endfunction

  // Most negative value representable in w bits (sign-extended).
  function automatic acc_t sat_lo(input int unsigned w);
    return ACC_MIN >>> (ACC_W_MAX - w);
  endfunction

  // Decide what stage 2 does with the registered product this cycle.
  function automatic acc_op_e decode_op(input logic stall, input logic valid,
                                        input logic clear);
    acc_op_e op;
    op = ACC_HOLD;
    if (!stall) begin
      if (clear && valid)  op = ACC_LOAD;
      else if (clear)      op = ACC_ZERO;
      else if (valid)      op = ACC_ADD;
    end
    return op;
  endfunction

endpackage

// File: rtl/pe_acc_adder.sv
// Combinational signed adder with overflow detect and optional saturation.
module pe_acc_adder
  import sauria_pe_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                sat_en,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  localparam acc_t HI_X = sat_hi(W);
  localparam acc_t LO_X = sat_lo(W);
  localparam logic signed [W-1:0] SAT_HI = HI_X[W-1:0];
  localparam logic signed [W-1:0] SAT_LO = LO_X[W-1:0];

  logic signed [W-1:0] raw;

  // Add, flag overflow on equal operand signs with a flipped result sign, clamp if enabled.
  always_comb begin
    raw = a + b;
    ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    sum = raw;
    if (sat_en && ovf) begin
      sum = a[W-1] ? SAT_LO : SAT_HI;
    end
  end

endmodule

// File: rtl/pe_accumulator.sv
// PE accumulator: registers the multiplier product, accumulates it into a
// partial sum, and hands finished sums to a shadow register on the shift chain.
module pe_accumulator
  import sauria_pe_pkg::*;
#(
  parameter int unsigned MUL_W  = 16,
  parameter int unsigned ACC_W  = 32,
  parameter bit          SAT_EN = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [MUL_W-1:0] i_prod,
  input  logic             i_prod_valid,
  input  logic             i_clear,
  input  logic             i_stall,
  input  logic             i_swap,
  input  logic             i_shift_en,
  input  logic [ACC_W-1:0] i_psum_in,
  output logic [ACC_W-1:0] o_psum_out,
  output logic             o_ovf_out,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_ovf
);

  logic signed [MUL_W-1:0] prod_q;
  logic                    valid_q;
  logic                    clear_q;

  logic signed [ACC_W-1:0] acc;
  logic                    ovf;
  logic        [ACC_W-1:0] shadow;
  logic                    shadow_ovf;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] add_sum;
  logic                    add_ovf;
  logic signed [ACC_W-1:0] acc_upd;
  logic                    ovf_upd;
  acc_op_e                 op;

  // Stage 1: capture the product and its qualifiers unless stalled.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
      clear_q <= 1'b0;
    end else if (!i_stall) begin
      prod_q  <= i_prod;
      valid_q <= i_prod_valid;
      clear_q <= i_clear;
    end
  end

  // Widen the registered product to accumulator width.
  always_comb begin
    prod_ext = ACC_W'(sext_prod(acc_t'($unsigned(prod_q)), MUL_W));
  end

  pe_acc_adder #(
    .W (ACC_W)
  ) u_adder (
    .a      (acc),
    .b      (prod_ext),
    .sat_en (SAT_EN),
    .sum    (add_sum),
    .ovf    (add_ovf)
  );

  // Stage 2: next accumulator value and sticky overflow.
  always_comb begin
    acc_upd = acc;
    ovf_upd = ovf;
    op      = decode_op(i_stall, valid_q, clear_q);
    unique case (op)
      ACC_LOAD: begin
        acc_upd = prod_ext;
        ovf_upd = 1'b0;
      end
      ACC_ZERO: begin
        acc_upd = '0;
        ovf_upd = 1'b0;
      end
      ACC_ADD: begin
        acc_upd = add_sum;
        ovf_upd = ovf | add_ovf;
      end
      default: ;
    endcase
  end

  // Accumulator and shadow chain. Swap takes acc_upd (not acc) so a product
  // retiring in the swap cycle lands in the shadow; swap overrides shift.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      acc        <= '0;
      ovf        <= 1'b0;
      shadow     <= '0;
      shadow_ovf <= 1'b0;
    end else if (i_swap) begin
      shadow     <= acc_upd;
      shadow_ovf <= ovf_upd;
      acc        <= '0;
      ovf        <= 1'b0;
    end else begin
      acc <= acc_upd;
      ovf <= ovf_upd;
      if (i_shift_en) begin
        shadow     <= i_psum_in;
        shadow_ovf <= 1'b0;
      end
    end
  end

  assign o_acc      = acc;
  assign o_ovf      = ovf;
  assign o_psum_out = shadow;
  assign o_ovf_out  = shadow_ovf;

endmodule

// File: tb/tb_pe_accumulator.sv
// Directed bench for pe_accumulator: one 32-bit wrapping instance plus two
// 17-bit instances (wrap and saturate) sharing the same stimulus.
module tb_pe_accumulator;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] prod;
  logic        valid, clear, stall, swap, shift;
  logic [31:0] psum_in;
  logic [16:0] psum_in17;

  logic [31:0] psum_out_a, acc_a;
  logic        ovf_out_a, ovf_a;
  logic [16:0] psum_out_w, acc_w;
  logic        ovf_out_w, ovf_w;
  logic [16:0] psum_out_s, acc_s;
  logic        ovf_out_s, ovf_s;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  pe_accumulator #(.MUL_W(16), .ACC_W(32), .SAT_EN(1'b0)) dut_a (
    .i_clk(clk), .i_rstn(rstn), .i_prod(prod), .i_prod_valid(valid),
    .i_clear(clear), .i_stall(stall), .i_swap(swap), .i_shift_en(shift),
    .i_psum_in(psum_in), .o_psum_out(psum_out_a), .o_ovf_out(ovf_out_a),
    .o_acc(acc_a), .o_ovf(ovf_a)
  );

  pe_accumulator #(.MUL_W(16), .ACC_W(17), .SAT_EN(1'b0)) dut_w (
    .i_clk(clk), .i_rstn(rstn), .i_prod(prod), .i_prod_valid(valid),
    .i_clear(clear), .i_stall(stall), .i_swap(swap), .i_shift_en(shift),
    .i_psum_in(psum_in17), .o_psum_out(psum_out_w), .o_ovf_out(ovf_out_w),
    .o_acc(acc_w), .o_ovf(ovf_w)
  );

  pe_accumulator #(.MUL_W(16), .ACC_W(17), .SAT_EN(1'b1)) dut_s (
    .i_clk(clk), .i_rstn(rstn), .i_prod(prod), .i_prod_valid(valid),
    .i_clear(clear), .i_stall(stall), .i_swap(swap), .i_shift_en(shift),
    .i_psum_in(psum_in17), .o_psum_out(psum_out_s), .o_ovf_out(ovf_out_s),
    .o_acc(acc_s), .o_ovf(ovf_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [15:0] p, input logic v, input logic c);
    prod  = p;
    valid = v;
    clear = c;
  endtask

  initial begin
    rstn = 1'b1;
    put(16'h0, 1'b0, 1'b0);
    stall = 1'b0; swap = 1'b0; shift = 1'b0;
    psum_in = '0; psum_in17 = '0;
    #1 rstn = 1'b0;
    #1;
    check("rst_acc",      64'(acc_a),      64'h0);
    check("rst_ovf",      64'(ovf_a),      64'h0);
    check("rst_psum_out", 64'(psum_out_a), 64'h0);
    check("rst_ovf_out",  64'(ovf_out_a),  64'h0);
    #10;
    @(negedge clk) rstn = 1'b1;
    tick();

    // Accumulate 3, -5, 7
    put(16'd3, 1'b1, 1'b1);    tick();
    put(16'hFFFB, 1'b1, 1'b0); tick();
    check("acc_3", 64'(acc_a), 64'd3);
    put(16'd7, 1'b1, 1'b0);    tick();
    check("acc_m2", 64'(acc_a), 64'(32'hFFFF_FFFE));
    put(16'd0, 1'b0, 1'b0);    tick();
    check("acc_5", 64'(acc_a), 64'd5);
    check("acc_ovf0", 64'(ovf_a), 64'h0);

    // Stall: 10 then 20, with a product presented while stalled
    put(16'd10, 1'b1, 1'b1); tick();
    put(16'd20, 1'b1, 1'b0); tick();
    check("stall_10", 64'(acc_a), 64'd10);
    stall = 1'b1;
    put(16'd99, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", 64'(acc_a), 64'd10);
    end
    stall = 1'b0;
    put(16'd0, 1'b0, 1'b0); tick();
    check("stall_30", 64'(acc_a), 64'd30);
    tick();
    check("stall_drop", 64'(acc_a), 64'd30);

    // Overflow: add 0x7FFF four times into 17-bit accumulators
    put(16'h7FFF, 1'b1, 1'b1); tick();
    put(16'h7FFF, 1'b1, 1'b0); tick();
    check("ovf_w_1", 64'(acc_w), 64'h07FFF);
    tick();
    check("ovf_w_2", 64'(acc_w), 64'h0FFFE);
    check("ovf_w_2f", 64'(ovf_w), 64'h0);
    tick();
    check("ovf_w_3", 64'(acc_w), 64'h17FFD);
    check("ovf_w_3f", 64'(ovf_w), 64'h1);
    check("ovf_s_3", 64'(acc_s), 64'h0FFFF);
    check("ovf_s_3f", 64'(ovf_s), 64'h1);
    put(16'd0, 1'b0, 1'b0); tick();
    check("ovf_w_4", 64'(acc_w), 64'h1FFFC);
    check("ovf_w_sticky", 64'(ovf_w), 64'h1);
    check("ovf_s_4", 64'(acc_s), 64'h0FFFF);
    check("ovf_a_4", 64'(acc_a), 64'h1FFFC);
    check("ovf_a_4f", 64'(ovf_a), 64'h0);

    // Swap carries the overflow flag with the sum
    swap = 1'b1; tick(); swap = 1'b0;
    check("swap_w_psum", 64'(psum_out_w), 64'h1FFFC);
    check("swap_w_ovfo", 64'(ovf_out_w), 64'h1);
    check("swap_s_psum", 64'(psum_out_s), 64'h0FFFF);
    check("swap_w_acc0", 64'(acc_w), 64'h0);
    check("swap_w_ovf0", 64'(ovf_w), 64'h0);

    // Shift loads upstream value and clears the shadow flag
    psum_in = 32'h1234; psum_in17 = 17'h1234;
    shift = 1'b1; tick(); shift = 1'b0;
    check("shift_psum", 64'(psum_out_a), 64'h1234);
    check("shift_ovfo", 64'(ovf_out_w), 64'h0);
    check("shift_psum_w", 64'(psum_out_w), 64'h1234);

    // Clear resets sticky overflow
    put(16'h7FFF, 1'b1, 1'b1); tick();
    put(16'h7FFF, 1'b1, 1'b0); tick();
    tick();
    put(16'd1, 1'b1, 1'b1); tick();
    check("clr_pre_ovf", 64'(ovf_s), 64'h1);
    put(16'd0, 1'b0, 1'b0); tick();
    check("clr_acc", 64'(acc_s), 64'h1);
    check("clr_ovf", 64'(ovf_s), 64'h0);

    // Swap with a product retiring in the same cycle
    put(16'd40, 1'b1, 1'b1); tick();
    put(16'd2, 1'b1, 1'b0);  tick();
    check("swap_pre40", 64'(acc_a), 64'd40);
    put(16'd0, 1'b0, 1'b0);
    swap = 1'b1; tick(); swap = 1'b0;
    check("swap_psum42", 64'(psum_out_a), 64'd42);
    check("swap_acc0", 64'(acc_a), 64'd0);
    put(16'd1, 1'b1, 1'b0); tick();
    put(16'd0, 1'b0, 1'b0); tick();
    check("swap_then1", 64'(acc_a), 64'd1);

    // Swap and shift together: swap wins
    put(16'd5, 1'b1, 1'b1); tick();
    put(16'd3, 1'b1, 1'b0); tick();
    put(16'd0, 1'b0, 1'b0);
    psum_in = 32'hABCD; psum_in17 = 17'hABCD;
    swap = 1'b1; shift = 1'b1; tick(); swap = 1'b0; shift = 1'b0;
    check("swsh_psum", 64'(psum_out_a), 64'd8);
    check("swsh_acc0", 64'(acc_a), 64'd0);

    // Swap during stall captures the held accumulator
    put(16'd6, 1'b1, 1'b1); tick();
    put(16'd4, 1'b1, 1'b0); tick();
    stall = 1'b1; swap = 1'b1; tick(); stall = 1'b0; swap = 1'b0;
    check("swst_psum", 64'(psum_out_a), 64'd6);
    check("swst_acc0", 64'(acc_a), 64'd0);
    put(16'd0, 1'b0, 1'b0); tick();
    check("swst_acc4", 64'(acc_a), 64'd4);

    // Asynchronous reset mid-accumulation, product in flight lost
    put(16'd9, 1'b1, 1'b0); tick();
    #2 rstn = 1'b0;
    #1;
    check("arst_acc",      64'(acc_a),      64'h0);
    check("arst_ovf_w",    64'(ovf_w),      64'h0);
    check("arst_psum_out", 64'(psum_out_a), 64'h0);
    check("arst_ovf_out",  64'(ovf_out_w),  64'h0);
    put(16'd0, 1'b0, 1'b0);
    @(negedge clk) rstn = 1'b1;
    tick(); tick();
    check("arst_lost", 64'(acc_a), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
